// File: rtl/alu_pkg.sv
// Shared instruction-format constants and opcode encoding for the ALU pipeline.
package alu_pkg;

  localparam int unsigned INSTR_W = 27;
  localparam int unsigned DATA_W  = 12;

  localparam int unsigned OPC_HI = 26;
  localparam int unsigned OPC_LO = 24;
  localparam int unsigned OP1_HI = 23;
  localparam int unsigned OP1_LO = 12;
  localparam int unsigned OP2_HI = 11;
  localparam int unsigned OP2_LO = 0;

  typedef enum logic [2:0] {
    OPC_ZERO = 3'b000,
    OPC_ADD  = 3'b001,
    OPC_SUB  = 3'b010,
    OPC_MULU = 3'b011,
    OPC_MULS = 3'b100,
    OPC_FADD = 3'b101,
    OPC_FMUL = 3'b110,
    OPC_CMP  = 3'b111
  } opcode_t;

  function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
    return opcode_t'(instr[OPC_HI:OPC_LO]);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in and result-out valid/ready handshakes of the ALU issue stage.
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic [2:0]         res_opcode;

  // master: instruction producer / result consumer; slave: the issue stage
  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data, res_opcode
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data, res_opcode
  );

endinterface

// File: rtl/alu_instr_fifo.sv
// Synchronous instruction FIFO with occupancy count and synchronous flush.
module alu_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned W     = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Feeds the combinational ALU from an instruction FIFO and registers its result
// behind a valid/ready handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  alu_issue_stage_if.slave   bus,
  output logic [INSTR_W-1:0] alu_instr,
  input  logic [DATA_W-1:0]  alu_out,
  output logic [CNT_W-1:0]   fifo_count
);

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [INSTR_W-1:0] fifo_head;
  logic               s2_free;
  logic               adv;

  logic               iss_valid;
  logic [INSTR_W-1:0] iss_instr;
  logic               res_valid;
  logic [DATA_W-1:0]  res_data;
  opcode_t            res_opcode;

  assign s2_free = !res_valid || bus.res_ready;
  assign adv     = iss_valid && s2_free;
  assign push    = bus.in_valid && !full;
  assign pop     = (!iss_valid || adv) && !empty;

  alu_instr_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .W     (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (bus.in_instr),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid  <= 1'b0;
      iss_instr  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= OPC_ZERO;
    end else if (flush) begin
      iss_valid <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (adv) begin
        res_data   <= alu_out;
        res_opcode <= instr_opcode(iss_instr);
        res_valid  <= 1'b1;
      end else if (res_valid && bus.res_ready) begin
        res_valid <= 1'b0;
      end

      if (pop) begin
        iss_instr <= fifo_head;
        iss_valid <= 1'b1;
      end else if (adv) begin
        iss_valid <= 1'b0;
      end
    end
  end

  // An idle issue slot presents opcode 000 so the ALU output is zero
  assign alu_instr      = iss_valid ? iss_instr : '0;
  assign bus.in_ready   = !full;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_data;
  assign bus.res_opcode = res_opcode;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small 8-bit-result ALU model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [26:0]      alu_instr;
  logic [11:0]      alu_out;
  logic [CNT_W-1:0] fifo_count;

  alu_issue_stage_if bus();

  alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .alu_instr  (alu_instr),
    .alu_out    (alu_out),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // ALU model: results keep the low 8 bits, zero-extended to 12
  function automatic logic [11:0] alu_model(input logic [26:0] i);
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] p;
    logic [11:0] r;
    a = i[23:12];
    b = i[11:0];
    p = a * b;
    r = '0;
    case (i[26:24])
      3'b001:  r = {4'h0, a[7:0] + b[7:0]};
      3'b010:  r = {4'h0, a[7:0] - b[7:0]};
      3'b011:  r = {4'h0, p[7:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_out = alu_model(alu_instr);

  function automatic logic [26:0] mk(input opcode_t o, input logic [11:0] a, input logic [11:0] b);
    return {o, a, b};
  endfunction

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic [14:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && !flush && bus.res_valid && bus.res_ready) begin
      got_q.push_back({bus.res_opcode, bus.res_data});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_one(input logic [26:0] i);
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic lat_check(input logic [26:0] i, input logic [11:0] exp, input logic [2:0] opc);
    bus.res_ready = 1'b1;
    push_one(i);
    chk("lat_edge1_valid", bus.res_valid, 0);
    chk("lat_edge1_count", fifo_count, 1);
    tick();
    chk("lat_edge2_valid", bus.res_valid, 0);
    chk("lat_edge2_alu_instr", alu_instr, i);
    tick();
    chk("lat_edge3_valid", bus.res_valid, 1);
    chk("lat_edge3_data", bus.res_data, exp);
    chk("lat_edge3_opcode", bus.res_opcode, opc);
    tick();
    chk("lat_edge4_drained", bus.res_valid, 0);
  endtask

  typedef struct {
    logic [26:0] instr;
    logic [11:0] exp_data;
    logic [2:0]  exp_opc;
  } vec_t;

  vec_t vec[9];

  initial begin
    int base;
    int n;
    int acc;
    int maxc;

    vec[0] = '{mk(OPC_ADD,  12'h005, 12'h003), 12'h008, 3'b001};
    vec[1] = '{mk(OPC_SUB,  12'h009, 12'h004), 12'h005, 3'b010};
    vec[2] = '{mk(OPC_ADD,  12'h0FF, 12'h001), 12'h000, 3'b001};
    vec[3] = '{mk(OPC_MULU, 12'h010, 12'h010), 12'h000, 3'b011};
    vec[4] = '{mk(OPC_MULU, 12'h00C, 12'h00B), 12'h084, 3'b011};
    vec[5] = '{mk(OPC_SUB,  12'h003, 12'h005), 12'h0FE, 3'b010};
    vec[6] = '{mk(OPC_ADD,  12'h0A0, 12'h050), 12'h0F0, 3'b001};
    vec[7] = '{mk(OPC_CMP,  12'h123, 12'h456), 12'h000, 3'b111};
    vec[8] = '{mk(OPC_ZERO, 12'hABC, 12'hDEF), 12'h000, 3'b000};

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.res_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_opcode", bus.res_opcode, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_alu_instr", alu_instr, 0);
    rst = 1'b0;

    lat_check(27'h1_005_003, 12'h008, 3'b001);

    for (int k = 0; k < 9; k++) begin
      base = got_q.size();
      bus.res_ready = 1'b1;
      push_one(vec[k].instr);
      n = 0;
      while (got_q.size() == base && n < 10) begin
        tick();
        n++;
      end
      if (got_q.size() == base) chk("vec_timeout", 0, 1);
      else begin
        chk("vec_data", got_q[base][11:0], vec[k].exp_data);
        chk("vec_opcode", got_q[base][14:12], vec[k].exp_opc);
      end
    end

    base = got_q.size();
    bus.res_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OPC_SUB, 12'h009, 12'h004); tick();
    bus.in_instr = mk(OPC_ADD, 12'h0FF, 12'h001); tick();
    bus.in_instr = mk(OPC_MULU, 12'h010, 12'h010); tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    chk("stream_count", got_q.size() - base, 3);
    if (got_q.size() >= base + 3) begin
      chk("stream_r0", got_q[base],     {3'b010, 12'h005});
      chk("stream_r1", got_q[base + 1], {3'b001, 12'h000});
      chk("stream_r2", got_q[base + 2], {3'b011, 12'h000});
      chk("stream_gap01", got_cyc[base + 1] - got_cyc[base], 1);
      chk("stream_gap12", got_cyc[base + 2] - got_cyc[base + 1], 1);
    end

    bus.res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = mk(OPC_ADD, 12'(32 + acc), 12'h001);
      if (k >= 6) chk("bp_in_ready_low", bus.in_ready, 0);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", acc, 6);
    chk("bp_fifo_count", fifo_count, 4);
    chk("bp_res_valid", bus.res_valid, 1);
    chk("bp_res_data", bus.res_data, 12'h021);
    repeat (3) tick();
    chk("bp_hold_data", bus.res_data, 12'h021);
    chk("bp_hold_opcode", bus.res_opcode, 3'b001);
    base = got_q.size();
    bus.res_ready = 1'b1;
    repeat (12) tick();
    chk("bp_drain_count", got_q.size() - base, 6);
    if (got_q.size() >= base + 6)
      for (int j = 0; j < 6; j++) chk("bp_drain_order", got_q[base + j][11:0], 12'(33 + j));

    base = got_q.size();
    acc = 0; maxc = 0; n = 0;
    while (acc < 3 * DEPTH && n < 300) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_instr = mk(OPC_ADD, 12'(64 + acc), 12'h000);
        acc++;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      n++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (20) tick();
    chk("wrap_pushed", acc, 3 * DEPTH);
    chk("wrap_maxcount_ok", maxc <= int'(DEPTH), 1);
    chk("wrap_count", got_q.size() - base, 3 * DEPTH);
    if (got_q.size() >= base + 3 * DEPTH)
      for (int j = 0; j < 3 * DEPTH; j++) chk("wrap_order", got_q[base + j][11:0], 12'(64 + j));

    bus.res_ready = 1'b0;
    base = got_q.size();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_instr = mk(OPC_ADD, 12'(16 + k), 12'h001);
      tick();
    end
    chk("flush_pre_count", fifo_count, 3);
    flush = 1'b1;
    bus.in_instr = mk(OPC_ADD, 12'h07F, 12'h001);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_res_valid", bus.res_valid, 0);
    chk("flush_fifo_count", fifo_count, 0);
    chk("flush_alu_instr", alu_instr, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    bus.res_ready = 1'b1;
    repeat (6) tick();
    chk("flush_no_output", got_q.size() - base, 0);

    bus.res_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_instr = mk(OPC_ADD, 12'(48 + k), 12'h001);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("rp_full_count", fifo_count, 4);
    chk("rp_full_in_ready", bus.in_ready, 0);
    chk("rp_pre_res_data", bus.res_data, 12'h031);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    chk("rp_in_ready", bus.in_ready, 1);
    chk("rp_res_valid", bus.res_valid, 0);
    chk("rp_res_data", bus.res_data, 0);
    chk("rp_res_opcode", bus.res_opcode, 0);
    chk("rp_fifo_count", fifo_count, 0);
    chk("rp_alu_instr", alu_instr, 0);
    lat_check(mk(OPC_ADD, 12'h001, 12'h001), 12'h002, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder and result-capture stage for the combinational 12-bit ALU.
- Buffers incoming 27-bit instructions in a small FIFO and holds one instruction in an issue register that drives the ALU instruction bus.
- Registers the ALU's 12-bit result, tagged with its opcode, behind a valid/ready handshake to the downstream consumer.
- Gives the purely combinational ALU a clocked, back-pressurable pipeline boundary.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of 2, minimum 2.
- CNT_W, 3, width of the fifo_count output; must be at least log2(DEPTH)+1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO, issue and result registers.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  FIFO can accept an instruction.
- in_instr  input  27  [26:24] opcode, [23:12] op1, [11:0] op2.
- alu_instr  output  27  instruction bus to the ALU.
- alu_out  input  12  combinational ALU result for alu_instr.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  12  captured ALU result.
- res_opcode  output  3  opcode that produced res_data.
- fifo_count  output  CNT_W  number of occupied FIFO entries.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst has priority over flush, which has priority over all other updates.
- Reset values: in_ready=1, res_valid=0, res_data=0, res_opcode=0, fifo_count=0, alu_instr=0, issue register empty.
- Push: when in_valid && in_ready, in_instr is written at the FIFO tail.
  - in_ready = !full, computed from registered state only; no combinational path from res_ready.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
- Result-stage free: s2_free = !res_valid || res_ready.
- Issue advance: adv = iss_valid && s2_free. On adv:
  - res_data <= alu_out;
  - res_opcode <= iss_instr[26:24];
  - res_valid <= 1.
- Result drain: if res_valid && res_ready && !adv, then res_valid <= 0.
- Issue load: when (!iss_valid || adv) && !fifo_empty, the FIFO head is popped into the issue register and iss_valid <= 1. Otherwise, on adv, iss_valid <= 0.
- ALU bus: alu_instr = iss_instr when iss_valid, else 27'h0 (opcode 000, so the ALU output is 0).
- Latency into an empty pipeline, with the push accepted at edge N:
  - FIFO write at edge N;
  - issue load at edge N+1;
  - result capture at edge N+2;
  - res_valid visible after edge N+2.
- Throughput: one result per cycle while res_ready=1 and the FIFO stays non-empty.
- Capacity: DEPTH + 2 instructions in flight (FIFO + issue + result).
- Simultaneous push and pop: allowed whenever not full; fifo_count stays unchanged.
- Pointers: DEPTH-modulo wrap-around. Full/empty are decided by a pointer extra bit or by fifo_count.
- Holding: res_data and res_opcode hold stable while res_valid && !res_ready.
- flush: empties the FIFO and clears iss_valid and res_valid in the same edge. A push in the flush cycle is dropped.
- Mid-operation reset or flush: discards all in-flight instructions. No partial result is emitted afterwards.

Decomposition:
- Shared package alu_pkg holds:
  - OPC_ZERO=3'b000, OPC_ADD=001, OPC_SUB=010, OPC_MULU=011, OPC_MULS=100, OPC_FADD=101, OPC_FMUL=110, OPC_CMP=111;
  - field constants OPC_HI=26, OPC_LO=24, OP1_HI=23, OP1_LO=12, OP2_HI=11, OP2_LO=0;
  - INSTR_W=27, DATA_W=12.
- One sub-module, alu_instr_fifo: a parameterised synchronous FIFO with push/pop/full/empty/count and flush. The issue and result registers stay in alu_issue_stage.

Test Plan:
- Single add: reset, then push 27'h1_005_003 (ADD, 0x005, 0x003) with res_ready=1 and the ALU instantiated. Required: res_valid rises after the 3rd edge, res_data=12'h008, res_opcode=3'b001, held for one cycle.
- Streaming: push SUB 0x009-0x004, ADD 0x0FF+0x001, MULU 0x010*0x010 back-to-back. Required: results 0x005, 0x000, 0x000 (low 8 bits of 0x100) on consecutive cycles, in order.
- Backpressure: hold res_ready=0 and offer 8 instructions. Required:
  - exactly 6 accepted; in_ready=0 from the 7th cycle on; fifo_count=4;
  - res_data stable while res_ready=0;
  - release res_ready, and all 6 results drain in order.
- Wrap-around: push/pop 3*DEPTH instructions with random res_ready. Required: no loss or duplication, order preserved, fifo_count never exceeds DEPTH.
- Flush mid-stream: with 5 in flight, assert flush for one cycle together with in_valid. Required: next cycle res_valid=0, fifo_count=0, alu_instr=0, in_ready=1; the flush-cycle push is not accepted.
- Reset priority: assert rst and flush together while full. Required: all outputs return to their reset values on the next edge; subsequent ADD 0x001+0x001 returns 0x002 with 3-edge latency.
